// File: rtl/demux_1x16_tdm.sv
// demux_1x16_tdm: serial TDM bit stream to 16 channel latches with frame assembly,
// mid-frame gap timeout and restart-on-frame_start abort detection.
module demux_1x16_tdm #(
  parameter int unsigned GAP_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_in,
  input  logic        in_valid,
  input  logic        frame_start,
  output logic [3:0]  select_lines,
  output logic [15:0] demux_outputs,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  output logic        frame_error
);
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam logic [7:0] GAP = 8'(GAP_LIMIT);
  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] dout_q, dout_d, fdata_q, fdata_d;
  logic        fv_q, fv_d, fe_q, fe_d;
  logic [7:0]  gap_q, gap_d, gap_inc;
  assign gap_inc = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    fdata_d = fdata_q;
    gap_d   = gap_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    if (in_valid && frame_start) begin
      fe_d      = (state_q == COLLECT);
      dout_d[0] = serial_in;
      sel_d     = 4'd1;
      gap_d     = '0;
      state_d   = COLLECT;
    end else if (state_q == COLLECT && in_valid) begin
      dout_d[sel_q] = serial_in;
      sel_d         = sel_q + 4'd1;
      gap_d         = '0;
      if (sel_q == 4'd15) begin
        fdata_d = {serial_in, dout_q[14:0]};
        fv_d    = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == COLLECT) begin
      gap_d = gap_inc;
      if (gap_inc >= GAP) begin
        fe_d    = 1'b1;
        sel_d   = '0;
        gap_d   = '0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dout_q  <= '0;
      fdata_q <= '0;
      gap_q   <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      fdata_q <= fdata_d;
      gap_q   <= gap_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end
  assign select_lines  = sel_q;
  assign demux_outputs = dout_q;
  assign frame_data    = fdata_q;
  assign frame_valid   = fv_q;
  assign frame_error   = fe_q;
endmodule

// File: tb/tb_demux_1x16_tdm.sv
// tb_demux_1x16_tdm: directed scenarios plus a random stream, checked against a
// frame-level reference model of the TDM demultiplexer.
module tb_demux_1x16_tdm;
  localparam int GAP = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  select_lines;
  logic [15:0] demux_outputs, frame_data;
  logic        frame_valid, frame_error;
  int n_vec = 0;
  int n_err = 0;
  bit         m_active;
  int         m_sel, m_gap;
  logic [15:0] m_dout, m_fdata;
  logic       m_fv, m_fe;

  demux_1x16_tdm #(.GAP_LIMIT(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .frame_start(frame_start), .select_lines(select_lines),
    .demux_outputs(demux_outputs), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_sel = 0; m_gap = 0;
    m_dout = '0; m_fdata = '0; m_fv = 0; m_fe = 0;
  endtask

  // Frame-level behaviour: a frame is 16 accepted bits opened by frame_start;
  // an idle run of GAP cycles or a fresh frame_start aborts it.
  task automatic model_edge(input logic v, input logic fs, input logic b);
    m_fv = 0; m_fe = 0;
    if (v && fs) begin
      if (m_active) m_fe = 1;
      m_active = 1; m_dout[0] = b; m_sel = 1; m_gap = 0;
    end else if (v && m_active) begin
      m_dout[m_sel] = b; m_gap = 0;
      if (m_sel == 15) begin
        m_fdata = m_dout; m_fv = 1; m_sel = 0; m_active = 0;
      end else m_sel = m_sel + 1;
    end else if (!v && m_active) begin
      m_gap = m_gap + 1;
      if (m_gap >= GAP) begin
        m_fe = 1; m_sel = 0; m_gap = 0; m_active = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic fs, input logic b);
    @(negedge clk);
    in_valid = v; frame_start = fs; serial_in = b;
    @(posedge clk);
    model_edge(v, fs, b);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_vec++;
    if ({select_lines, demux_outputs, frame_data, frame_valid, frame_error} !== 38'd0) begin
      n_err++;
      $display("FAIL reset: got sel=%0d dout=%h fdata=%h fv=%b fe=%b, want all zero",
               select_lines, demux_outputs, frame_data, frame_valid, frame_error);
    end
  endtask

  task automatic test_aaaa();
    logic [15:0] w = 16'hAAAA;
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (select_lines !== 4'(i)) begin
        n_err++;
        $display("FAIL aaaa_sel: got %0d want %0d", select_lines, i);
      end
      step(1'b1, i == 0, w[i]);
      if (frame_valid) pulses++;
    end
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data !== 16'hAAAA || select_lines !== 4'd0) begin
      n_err++;
      $display("FAIL aaaa_frame: got fv=%b fdata=%h sel=%0d want fv=1 fdata=aaaa sel=0",
               frame_valid, frame_data, select_lines);
    end
    step(1'b0, 1'b0, 1'b0);
    if (frame_valid) pulses++;
    n_vec++;
    if (pulses != 1 || frame_error !== 1'b0) begin
      n_err++;
      $display("FAIL aaaa_pulse: got %0d pulses fe=%b want 1 pulse fe=0", pulses, frame_error);
    end
  endtask

  task automatic test_gap_ok();
    logic [15:0] w = 16'hCCCC;
    int errs = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      if (i == 7) for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0, 1'b0);
        if (frame_error) errs++;
      end
    end
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data !== 16'hCCCC || errs != 0 || frame_error !== 1'b0) begin
      n_err++;
      $display("FAIL gap_ok: got fv=%b fdata=%h err_pulses=%0d want fv=1 fdata=cccc 0 errors",
               frame_valid, frame_data, errs);
    end
  endtask

  task automatic test_gap_abort();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'($urandom));
    for (int k = 1; k <= GAP; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (frame_error !== (k == GAP)) begin
        n_err++;
        $display("FAIL gap_abort_fe idle=%0d: got %b want %b", k, frame_error, k == GAP);
      end
    end
    n_vec++;
    if (select_lines !== 4'd0 || frame_data !== 16'hCCCC || demux_outputs !== m_dout) begin
      n_err++;
      $display("FAIL gap_abort_state: got sel=%0d fdata=%h dout=%h want sel=0 fdata=cccc dout=%h",
               select_lines, frame_data, demux_outputs, m_dout);
    end
    step(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (frame_error !== 1'b0) begin
      n_err++;
      $display("FAIL gap_abort_pulse: got fe=%b want 0", frame_error);
    end
  endtask

  task automatic test_restart();
    logic [15:0] w = 16'h1234;
    int fe_cnt = 0, fv_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      if (i == 0) begin
        n_vec++;
        if (frame_error !== 1'b1 || frame_valid !== 1'b0 || select_lines !== 4'd1) begin
          n_err++;
          $display("FAIL restart_err: got fe=%b fv=%b sel=%0d want fe=1 fv=0 sel=1",
                   frame_error, frame_valid, select_lines);
        end
      end
      fe_cnt += int'(frame_error);
      fv_cnt += int'(frame_valid);
    end
    n_vec++;
    if (frame_data !== 16'h1234 || fe_cnt != 1 || fv_cnt != 1) begin
      n_err++;
      $display("FAIL restart_frame: got fdata=%h fe_cnt=%0d fv_cnt=%0d want 1234 1 1",
               frame_data, fe_cnt, fv_cnt);
    end
  endtask

  task automatic test_idle_ignore();
    logic [15:0] d0 = demux_outputs, f0 = frame_data;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'($urandom));
      if (demux_outputs !== d0 || frame_data !== f0 || select_lines !== 4'd0 ||
          frame_valid !== 1'b0 || frame_error !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0 || d0 !== m_dout || f0 !== 16'h1234) begin
      n_err++;
      $display("FAIL idle_ignore: %0d changed cycles, dout=%h fdata=%h want 0 changes dout=%h fdata=1234",
               bad, demux_outputs, frame_data, m_dout);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w = 16'h5A5A;
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({select_lines, demux_outputs, frame_data, frame_valid, frame_error} !== 38'd0) begin
      n_err++;
      $display("FAIL async_reset: got sel=%0d dout=%h fdata=%h fv=%b fe=%b, want all zero",
               select_lines, demux_outputs, frame_data, frame_valid, frame_error);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({select_lines, demux_outputs, frame_data, frame_valid, frame_error} !== 38'd0) begin
      n_err++;
      $display("FAIL post_reset_ignore: got sel=%0d dout=%h fdata=%h fe=%b, want all zero",
               select_lines, demux_outputs, frame_data, frame_error);
    end
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, w[i]);
    n_vec++;
    if (frame_data !== 16'h5A5A || frame_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_frame: got fdata=%h fv=%b want 5a5a 1", frame_data, frame_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 49) == 0)
        repeat ($urandom_range(GAP - 1, GAP + 2)) step(1'b0, 1'b0, 1'b0);
      else
        step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom));
      n_vec++;
      if ({select_lines, demux_outputs, frame_data, frame_valid, frame_error} !==
          {4'(m_sel), m_dout, m_fdata, m_fv, m_fe} || (frame_valid && frame_error)) begin
        n_err++;
        $display("FAIL random cyc=%0d: got sel=%0d dout=%h fdata=%h fv=%b fe=%b want sel=%0d dout=%h fdata=%h fv=%b fe=%b",
                 c, select_lines, demux_outputs, frame_data, frame_valid, frame_error,
                 m_sel, m_dout, m_fdata, m_fv, m_fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aaaa();
    test_gap_ok();
    test_gap_abort();
    test_restart();
    test_idle_ignore();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end
endmodule

// File: doc/demux_1x16_tdm.md
DEMUX_1X16_TDM -- requirements
Module: demux_1x16_tdm

Interface
REQ-001 Parameter GAP_LIMIT, default 8, sets the number of consecutive idle cycles allowed mid-frame before the frame is aborted (legal range 1..255).
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, is an asynchronous, active-low reset.
REQ-004 Port serial_in, input, 1, carries the TDM data bit for the current channel.
REQ-005 Port in_valid, input, 1, marks serial_in as valid this cycle.
REQ-006 Port frame_start, input, 1, marks the bit as channel 0 of a new frame; it is only sampled when in_valid=1.
REQ-007 Port select_lines, output, 4, is the channel index the next accepted bit is written to.
REQ-008 Port demux_outputs, output, 16, holds the live per-channel latches; bit k is the last bit accepted for channel k.
REQ-009 Port frame_data, output, 16, holds the last complete frame; bit k = channel k.
REQ-010 Port frame_valid, output, 1, is a 1-cycle pulse indicating that frame_data was updated.
REQ-011 Port frame_error, output, 1, is a 1-cycle pulse indicating a frame was aborted.

Function
REQ-012 The FSM shall have exactly two states, IDLE and COLLECT; the state is registered.
REQ-013 In IDLE, in_valid=1 with frame_start=1 shall write serial_in to demux_outputs[0], set select_lines=1, clear the gap counter and enter COLLECT.
REQ-014 In IDLE, in_valid=1 with frame_start=0 shall be ignored: no output changes and no error.
REQ-015 In COLLECT, in_valid=1 with frame_start=0 shall write serial_in to demux_outputs[select_lines], increment select_lines and clear the gap counter.
REQ-016 When the bit for channel 15 is accepted, the block shall, on that same edge, load frame_data with the assembled 16 bits (including the channel-15 bit), assert frame_valid for the following cycle, set select_lines=0 and return to IDLE.
REQ-017 Latency from the channel-15 bit accept edge to frame_valid=1 and new frame_data visible shall be 1 clock; frame_data shall hold until the next completed frame.
REQ-018 In COLLECT, in_valid=1 with frame_start=1 shall pulse frame_error, discard the partial frame, treat the bit as channel 0 of a new frame (as in REQ-013) and remain in COLLECT.
REQ-019 In COLLECT, each cycle with in_valid=0 shall increment the gap counter; when the count reaches GAP_LIMIT, the block shall pulse frame_error, set select_lines=0, clear the gap counter and return to IDLE.
REQ-020 On an abort, frame_data shall not change; demux_outputs shall retain the bits already written.
REQ-021 The gap counter shall saturate and must not wrap; select_lines wraps 15->0 only through REQ-016.
REQ-022 frame_valid and frame_error shall never be asserted in the same cycle.
REQ-023 All outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-024 While rst_n=0, the block shall immediately force state=IDLE, select_lines=0, demux_outputs=16'h0000, frame_data=16'h0000, frame_valid=0, frame_error=0 and gap counter=0, independent of clk.
REQ-025 Reset asserted mid-frame shall discard the partial frame without pulsing frame_error; after deassertion, the first accepted bit must carry frame_start=1.

Verification
REQ-026 Stream 16'hAAAA, channel 0 first, with in_valid held high and frame_start on bit 0 -> frame_valid pulses once, 1 cycle after the 16th bit; frame_data=16'hAAAA; select_lines counts 0..15 then returns to 0.
REQ-027 Stream 16'hCCCC with in_valid low for 3 cycles after channel 7 (GAP_LIMIT=8) -> frame_data=16'hCCCC, frame_valid=1 pulse, frame_error=0.
REQ-028 Send 5 bits, then hold in_valid low for 8 cycles -> frame_error pulses on the 8th idle cycle; select_lines=0; frame_data keeps its previous value.
REQ-029 Send 10 bits, then a bit with frame_start=1 followed by 16'h1234 -> one frame_error pulse, then frame_data=16'h1234 with one frame_valid pulse.
REQ-030 Apply rst_n=0 mid-frame asynchronously between clock edges -> all outputs are zero immediately; bits without frame_start after release are ignored.
REQ-031 Send in_valid=1 with frame_start=0 in IDLE for 20 cycles -> no output changes.
